// File: rtl/controle_bombas_multi_pkg.sv
// Shared definitions for the multi-channel pump controller: channel state
// encoding, default prescaler length and channel-index width helper.
package controle_bombas_multi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TICK_CICLOS_PADRAO = 50000;

    // Channel index width, never narrower than one bit.
    function automatic int canal_largura(input int num_canais);
        return (num_canais > 1) ? $clog2(num_canais) : 1;
    endfunction

endpackage

// File: rtl/controle_bombas_multi_if.sv
// Command/status bundle of the pump controller; master issues liga/para,
// slave (the controller) drives pump and status outputs.
interface controle_bombas_multi_if #(
    parameter int NUM_CANAIS = 2,
    parameter int DUR_W      = 16
);
    import controle_bombas_multi_pkg::*;

    localparam int CANAL_W = canal_largura(NUM_CANAIS);

    logic                  liga;
    logic [CANAL_W-1:0]    canal;
    logic [DUR_W-1:0]      duracao;
    logic [NUM_CANAIS-1:0] para;
    logic [NUM_CANAIS-1:0] bomba;
    logic [NUM_CANAIS-1:0] ocupado;
    logic [NUM_CANAIS-1:0] fim_bomba;
    logic                  erro;

    modport master (
        output liga, canal, duracao, para,
        input  bomba, ocupado, fim_bomba, erro
    );

    modport slave (
        input  liga, canal, duracao, para,
        output bomba, ocupado, fim_bomba, erro
    );

endinterface

// File: rtl/controle_bombas_multi_canal_bomba.sv
// One pump channel: IDLE/RUN/DONE state machine with its own remaining-tick
// counter; all outputs are registered decodes of the next state.
module canal_bomba
    import controle_bombas_multi_pkg::*;
#(
    parameter int DUR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             para_i,
    input  logic [DUR_W-1:0] duracao_i,
    output logic             bomba_o,
    output logic             ocupado_o,
    output logic             fim_o
);

    logic [1:0]       estado_q, estado_d;
    logic [DUR_W-1:0] rest_q, rest_d;
    logic             bomba_q, ocupado_q, fim_q;

    // Next-state and remaining-count logic; an abort wins over the final tick.
    always_comb begin
        estado_d = estado_q;
        rest_d   = rest_q;
        case (estado_q)
            ST_IDLE: begin
                if (start_i) begin
                    estado_d = ST_RUN;
                    rest_d   = duracao_i;
                end else begin
                    estado_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (para_i) begin
                    estado_d = ST_IDLE;
                    rest_d   = {DUR_W{1'b0}};
                end else if (tick_i) begin
                    if (rest_q == DUR_W'(1)) begin
                        estado_d = ST_DONE;
                        rest_d   = {DUR_W{1'b0}};
                    end else begin
                        rest_d   = rest_q - DUR_W'(1);
                    end
                end else begin
                    rest_d = rest_q;
                end
            end
            ST_DONE: begin
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
                rest_d   = {DUR_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered output decodes with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= ST_IDLE;
            rest_q    <= {DUR_W{1'b0}};
            bomba_q   <= 1'b0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            rest_q    <= rest_d;
            bomba_q   <= (estado_d == ST_RUN);
            ocupado_q <= (estado_d != ST_IDLE);
            fim_q     <= (estado_d == ST_DONE);
        end
    end

    assign bomba_o   = bomba_q;
    assign ocupado_o = ocupado_q;
    assign fim_o     = fim_q;

endmodule

// File: rtl/controle_bombas_multi.sv
// Multi-channel pump controller top: shared tick prescaler, liga acceptance
// and erro pulse, and one canal_bomba instance per channel.
module controle_bombas_multi
    import controle_bombas_multi_pkg::*;
#(
    parameter int NUM_CANAIS  = 2,
    parameter int TICK_CICLOS = TICK_CICLOS_PADRAO,
    parameter int DUR_W       = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    controle_bombas_multi_if.slave  bus
);

    localparam int CANAL_W = canal_largura(NUM_CANAIS);
    localparam int PRESC_W = $clog2(TICK_CICLOS);

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  tick_s;
    logic                  faixa_s;
    logic                  ocupado_sel_s;
    logic                  aceita_s;
    logic                  erro_q;
    logic [NUM_CANAIS-1:0] start_s;
    logic [NUM_CANAIS-1:0] bomba_s, ocupado_s, fim_s;

    assign tick_s = (presc_q == PRESC_W'(TICK_CICLOS - 1));

    // Free-running prescaler wrapping at TICK_CICLOS-1.
    always_comb begin
        if (tick_s) begin
            presc_d = {PRESC_W{1'b0}};
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Busy status of the addressed channel; out-of-range indexes read as idle
    // here and are rejected by the range check instead.
    always_comb begin
        ocupado_sel_s = 1'b0;
        for (int i = 0; i < NUM_CANAIS; i++) begin
            if (bus.canal == CANAL_W'(i)) begin
                ocupado_sel_s = ocupado_s[i];
            end else begin
                ocupado_sel_s = ocupado_sel_s;
            end
        end
    end

    assign faixa_s  = ({1'b0, bus.canal} < (CANAL_W + 1)'(NUM_CANAIS));
    assign aceita_s = bus.liga && !reset && faixa_s && !ocupado_sel_s
                      && (bus.duracao != {DUR_W{1'b0}});

    // Prescaler and rejected-request pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= {PRESC_W{1'b0}};
            erro_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            erro_q  <= bus.liga && !aceita_s;
        end
    end

    for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
        assign start_s[i] = aceita_s && (bus.canal == CANAL_W'(i));

        canal_bomba #(
            .DUR_W (DUR_W)
        ) u_canal (
            .clock     (clock),
            .reset     (reset),
            .tick_i    (tick_s),
            .start_i   (start_s[i]),
            .para_i    (bus.para[i]),
            .duracao_i (bus.duracao),
            .bomba_o   (bomba_s[i]),
            .ocupado_o (ocupado_s[i]),
            .fim_o     (fim_s[i])
        );
    end

    assign bus.bomba     = bomba_s;
    assign bus.ocupado   = ocupado_s;
    assign bus.fim_bomba = fim_s;
    assign bus.erro      = erro_q;

endmodule

// File: tb/tb_controle_bombas_multi.sv
// Directed bench for controle_bombas_multi with TICK_CICLOS=4, DUR_W=8; a
// 2-channel instance plus a 3-channel instance for out-of-range canal.
module tb_controle_bombas_multi;

    logic clock;
    logic reset;

    controle_bombas_multi_if #(.NUM_CANAIS(2), .DUR_W(8)) bus  ();
    controle_bombas_multi_if #(.NUM_CANAIS(3), .DUR_W(8)) bus3 ();

    controle_bombas_multi #(.NUM_CANAIS(2), .TICK_CICLOS(4), .DUR_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    controle_bombas_multi #(.NUM_CANAIS(3), .TICK_CICLOS(4), .DUR_W(8)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;
    int aceitos    [2] = '{0, 0};
    int cancelados [2] = '{0, 0};
    int fim_vistos [2] = '{0, 0};
    int n;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each edge; every fim pulse
    // must close exactly one outstanding accepted liga on its channel.
    task automatic step(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (bus.fim_bomba[c] === 1'b1) begin
                    checks++;
                    assert (fim_vistos[c] + cancelados[c] + 1 == aceitos[c]) else begin
                        failures++;
                        $error("FAIL fim_sem_liga ch%0d got=%0d expected=%0d",
                               c, fim_vistos[c] + cancelados[c] + 1, aceitos[c]);
                    end
                    fim_vistos[c]++;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.liga = 1'b0;  bus.canal = 1'b0;  bus.duracao = 8'd0;  bus.para = 2'b00;
        bus3.liga = 1'b0; bus3.canal = 2'd0; bus3.duracao = 8'd0; bus3.para = 3'b000;

        step(2);
        chk("rst_bomba",   bus.bomba,     32'h0);
        chk("rst_ocupado", bus.ocupado,   32'h0);
        chk("rst_fim",     bus.fim_bomba, 32'h0);
        chk("rst_erro",    bus.erro,      32'h0);

        // Single run, duracao=3, started at prescaler phase 0.
        reset = 1'b0;
        bus.liga = 1'b1; bus.canal = 1'b0; bus.duracao = 8'd3; aceitos[0]++;
        step(1);
        bus.liga = 1'b0;
        chk("run_bomba",   bus.bomba,   32'h1);
        chk("run_ocupado", bus.ocupado, 32'h1);
        n = 1;
        while (bus.bomba[0] === 1'b1 && n < 50) begin
            step(1);
            if (bus.bomba[0] === 1'b1) n++;
        end
        chk("high_cycles", n, 32'd11);
        chk("high_range",  (n >= 9 && n <= 12), 32'h1);
        chk("fim_pulse",   bus.fim_bomba, 32'h1);
        chk("done_ocup",   bus.ocupado,   32'h1);
        step(1);
        chk("fim_clear",   bus.fim_bomba, 32'h0);
        chk("idle_ocup",   bus.ocupado,   32'h0);

        // Overlapping channels.
        bus.liga = 1'b1; bus.canal = 1'b0; bus.duracao = 8'd5; aceitos[0]++;
        step(1);
        bus.liga = 1'b0;
        step(2);
        bus.liga = 1'b1; bus.canal = 1'b1; bus.duracao = 8'd2; aceitos[1]++;
        step(1);
        bus.liga = 1'b0;
        chk("ovl_bomba",   bus.bomba,   32'h3);
        chk("ovl_ocupado", bus.ocupado, 32'h3);
        step(7);
        chk("ovl_fim1",    bus.fim_bomba, 32'h2);
        chk("ovl_bomba0",  bus.bomba,     32'h1);
        step(1);
        chk("ovl_ocup1",   bus.ocupado,   32'h1);
        step(7);
        chk("ovl_fim0",    bus.fim_bomba, 32'h1);
        chk("ovl_bomba_z", bus.bomba,     32'h0);
        step(1);
        chk("ovl_idle",    bus.ocupado,   32'h0);

        // Rejections on the 3-channel instance.
        bus3.liga = 1'b1; bus3.canal = 2'd0; bus3.duracao = 8'd4;
        step(1);
        chk("rej_ok_erro", bus3.erro,    32'h0);
        chk("rej_ok_ocup", bus3.ocupado, 32'h1);
        bus3.canal = 2'd0; bus3.duracao = 8'd2;
        step(1);
        chk("rej_busy_erro", bus3.erro,    32'h1);
        chk("rej_busy_ocup", bus3.ocupado, 32'h1);
        bus3.canal = 2'd1; bus3.duracao = 8'd0;
        step(1);
        chk("rej_dur0_erro", bus3.erro,    32'h1);
        chk("rej_dur0_ocup", bus3.ocupado, 32'h1);
        bus3.canal = 2'd3; bus3.duracao = 8'd5;
        step(1);
        chk("rej_range_erro", bus3.erro,    32'h1);
        chk("rej_range_ocup", bus3.ocupado, 32'h1);
        chk("rej_main_erro",  bus.erro,     32'h0);
        bus3.liga = 1'b0;
        step(1);
        chk("rej_erro_clr", bus3.erro, 32'h0);
        step(9);
        chk("rej_still_run", bus3.bomba, 32'h1);
        step(1);
        chk("rej_fim",  bus3.fim_bomba, 32'h1);
        chk("rej_stop", bus3.bomba,     32'h0);
        step(1);
        chk("rej_idle", bus3.ocupado, 32'h0);

        // Abort mid-run.
        bus.liga = 1'b1; bus.canal = 1'b0; bus.duracao = 8'd3; aceitos[0]++;
        step(1);
        bus.liga = 1'b0;
        chk("ab_bomba", bus.bomba, 32'h1);
        step(3);
        bus.para = 2'b01;
        step(1);
        cancelados[0]++;
        bus.para = 2'b00;
        chk("ab_bomba_z", bus.bomba,     32'h0);
        chk("ab_ocup_z",  bus.ocupado,   32'h0);
        chk("ab_fim_z",   bus.fim_bomba, 32'h0);

        // Abort coinciding with the final tick.
        bus.liga = 1'b1; bus.canal = 1'b0; bus.duracao = 8'd2; aceitos[0]++;
        step(1);
        bus.liga = 1'b0;
        chk("abf_bomba", bus.bomba, 32'h1);
        step(4);
        chk("abf_pre", bus.bomba, 32'h1);
        bus.para = 2'b01;
        step(1);
        cancelados[0]++;
        bus.para = 2'b00;
        chk("abf_bomba_z", bus.bomba,     32'h0);
        chk("abf_ocup_z",  bus.ocupado,   32'h0);
        chk("abf_fim_z",   bus.fim_bomba, 32'h0);
        step(1);
        chk("abf_fim_z2",  bus.fim_bomba, 32'h0);

        // liga and para together on an idle channel.
        bus.liga = 1'b1; bus.canal = 1'b1; bus.duracao = 8'd1; bus.para = 2'b10; aceitos[1]++;
        step(1);
        bus.liga = 1'b0; bus.para = 2'b00;
        chk("lp_bomba", bus.bomba,   32'h2);
        chk("lp_ocup",  bus.ocupado, 32'h2);
        step(2);
        chk("lp_fim",   bus.fim_bomba, 32'h2);
        chk("lp_stop",  bus.bomba,     32'h0);
        step(1);
        chk("lp_idle",  bus.ocupado,   32'h0);

        // Reset while both channels run; liga held during reset is ignored.
        bus.liga = 1'b1; bus.canal = 1'b0; bus.duracao = 8'd5; aceitos[0]++;
        step(1);
        bus.canal = 1'b1; aceitos[1]++;
        step(1);
        chk("rr_bomba", bus.bomba, 32'h3);
        reset = 1'b1;
        bus.canal = 1'b0; bus.duracao = 8'd2;
        cancelados[0]++; cancelados[1]++;
        step(1);
        chk("rr_bomba_z", bus.bomba,     32'h0);
        chk("rr_ocup_z",  bus.ocupado,   32'h0);
        chk("rr_fim_z",   bus.fim_bomba, 32'h0);
        chk("rr_erro_z",  bus.erro,      32'h0);
        step(1);
        chk("rr_liga_ign", bus.ocupado, 32'h0);
        chk("rr_erro_ign", bus.erro,    32'h0);
        reset = 1'b0; aceitos[0]++;
        step(1);
        bus.liga = 1'b0;
        chk("rr_restart", bus.bomba,   32'h1);
        chk("rr_ocup",    bus.ocupado, 32'h1);
        step(6);
        chk("rr_pre_fim", bus.bomba,     32'h1);
        chk("rr_no_fim",  bus.fim_bomba, 32'h0);
        step(1);
        chk("rr_fim",  bus.fim_bomba, 32'h1);
        chk("rr_stop", bus.bomba,     32'h0);
        step(1);
        chk("rr_idle", bus.ocupado, 32'h0);

        chk("fim_count0", fim_vistos[0], 32'd3);
        chk("fim_count1", fim_vistos[1], 32'd2);
        chk("balance0", fim_vistos[0] + cancelados[0], aceitos[0]);
        chk("balance1", fim_vistos[1] + cancelados[1], aceitos[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
